uart_rx_dev: RTL and testbench

// - Bus-attached UART receiver peripheral; the inbound counterpart of the uart TX device on the demo-system bus.
// - Sits on one bus device slot (device_req/addr/we/be/wdata -> rvalid/rdata).
// - Deserialises 8N1 frames from uart_rx_i into a byte FIFO that the core reads over the bus.
// - Raises a level interrupt to Ibex (irq_fast) when data or an error is pending.

---
 rtl/uart_rx_dev.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_rx_dev.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_dev.sv
// ---------------------------------------------------------------------------
// uart_rx_dev
//   Bus-attached UART receiver. Deserialises 8N1 frames (8E1 when
//   UART_RX_PARITY_EN is defined) from uart_rx_i into a byte FIFO that the
//   core drains over the device bus. Raises a level interrupt when data or an
//   error is pending and the interrupt is enabled.
//
//   Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
//
// Ports
//   clk_sys_i        system clock
//   rst_sys_ni       asynchronous active-low reset
//   device_req_i     bus request (always granted)
//   device_addr_i    byte address, [3:2] select the register
//   device_we_i      1 = write
//   device_be_i      byte enables, be[0] qualifies STATUS/CTRL writes
//   device_wdata_i   write data
//   device_rvalid_o  response valid, one cycle after every request
//   device_rdata_o   read data (0 for writes)
//   uart_rx_i        asynchronous serial input, idle high
//   rx_irq_o         level interrupt
//
// Register map (addr[3:2])
//   0 RX_DATA  RO  {1'b0,23'b0,byte} and pop, or 32'h8000_0000 when empty
//   1 STATUS   W1C {parity_err,frame_err,overrun,full,not_empty}
//   2 CTRL     RW  bit0 irq_en
//   3 -        reads 0, writes ignored
// ---------------------------------------------------------------------------
module uart_rx_dev #(
   parameter int unsigned ClockFrequency = 50_000_000,
   parameter int unsigned BaudRate       = 115_200,
   parameter int unsigned FifoDepth      = 8
) (
   input  logic        clk_sys_i,
   input  logic        rst_sys_ni,
   input  logic        device_req_i,
   input  logic [31:0] device_addr_i,
   input  logic        device_we_i,
   input  logic [3:0]  device_be_i,
   input  logic [31:0] device_wdata_i,
   output logic        device_rvalid_o,
   output logic [31:0] device_rdata_o,
   input  logic        uart_rx_i,
   output logic        rx_irq_o
);

   localparam int unsigned ClocksPerBit = ClockFrequency / BaudRate;
   localparam int unsigned CntW         = $clog2(ClocksPerBit);
   localparam int unsigned AddrW        = $clog2(FifoDepth);
   localparam int unsigned PtrW         = AddrW + 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   // ------------------------------------------------------------------
   // Input synchroniser and start-edge qualification
   // ------------------------------------------------------------------
   logic       rx_s1_q, rx_s2_q, rx_prev_q;
   logic [1:0] sync_fill_q;
   logic       armed_q;
   logic       fall_edge;

   // sync_fill_q marks when rx_s2_q holds a real line sample rather than the
   // reset value, so a line held low from reset never arms the receiver.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         sync_fill_q <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         rx_s1_q     <= uart_rx_i;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         sync_fill_q <= {sync_fill_q[0], 1'b1};
         if (sync_fill_q[1] && rx_s2_q) armed_q <= 1'b1;
      end
   end

   assign fall_edge = armed_q & rx_prev_q & ~rx_s2_q;

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tick;
   logic            push_req;
   logic            frame_set;
`ifdef UART_RX_PARITY_EN
   logic            parity_set;
`endif

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   assign tick = (cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      push_req   = 1'b0;
      frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_set = 1'b0;
`endif
      if (state_q != StIdle && !tick) cnt_d = cnt_q - 1'b1;

      case (state_q)
         StIdle: begin
            if (fall_edge) begin
               state_d = StStart;
               cnt_d   = CntW'(ClocksPerBit / 2);
            end
         end
         StStart: begin
            if (tick) begin
               if (rx_s2_q) begin
                  // Line back high at mid start bit: a glitch, not a frame.
                  state_d = StIdle;
               end else begin
                  state_d   = StData;
                  cnt_d     = CntW'(ClocksPerBit - 1);
                  bit_idx_d = '0;
               end
            end
         end
         StData: begin
            if (tick) begin
               shift_d = {rx_s2_q, shift_q[7:1]};
               cnt_d   = CntW'(ClocksPerBit - 1);
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (tick) begin
               // Even parity: data bits plus parity bit XOR to zero.
               parity_set = rx_s2_q ^ (^shift_q);
               state_d    = StStop;
               cnt_d      = CntW'(ClocksPerBit - 1);
            end
         end
`endif
         StStop: begin
            if (tick) begin
               if (rx_s2_q) push_req  = 1'b1;
               else         frame_set = 1'b1;
               // Straight back to IDLE so a start bit right after the stop
               // bit's sample point is still seen.
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic [1:0] reg_sel;
   logic       rd_req, wr_req;
   assign reg_sel = device_addr_i[3:2];
   assign rd_req  = device_req_i & ~device_we_i;
   assign wr_req  = device_req_i &  device_we_i;

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   logic [7:0]      mem_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic            empty, full;
   logic            pop, do_push, overrun_set;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &
                  (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);

   // A pop on a full FIFO frees the slot the simultaneous push needs.
   assign pop         = rd_req & (reg_sel == 2'd0) & ~empty;
   assign do_push     = push_req & (~full | pop);
   assign overrun_set = push_req & full & ~pop;

   always_ff @(posedge clk_sys_i) begin
      if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Status flags, control, interrupt
   // ------------------------------------------------------------------
   logic status_clr;
   logic overrun_q, frame_err_q, parity_err;
   logic irq_en_q, irq_q;

   assign status_clr = wr_req & (reg_sel == 2'd1) & device_be_i[0];

   // Set has priority over a same-cycle W1C.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         overrun_q   <= overrun_set | (overrun_q   & ~(status_clr & device_wdata_i[2]));
         frame_err_q <= frame_set   | (frame_err_q & ~(status_clr & device_wdata_i[3]));
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) parity_err_q <= 1'b0;
      else parity_err_q <= parity_set | (parity_err_q & ~(status_clr & device_wdata_i[4]));
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_req && reg_sel == 2'd2 && device_be_i[0]) irq_en_q <= device_wdata_i[0];
         irq_q <= irq_en_q & (~empty | overrun_q | frame_err_q | parity_err);
      end
   end

   assign rx_irq_o = irq_q;

   // ------------------------------------------------------------------
   // Read response
   // ------------------------------------------------------------------
   logic [31:0] status;
   logic [31:0] rdata_d, rdata_q;
   logic        rvalid_q;

   assign status = {27'b0, parity_err, frame_err_q, overrun_q, full, ~empty};

   always_comb begin
      rdata_d = '0;
      if (rd_req) begin
         case (reg_sel)
            2'd0:    rdata_d = empty ? 32'h8000_0000 : {24'b0, mem_q[rd_ptr_q[AddrW-1:0]]};
            2'd1:    rdata_d = status;
            2'd2:    rdata_d = {31'b0, irq_en_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= device_req_i;
         rdata_q  <= rdata_d;
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;

   // Bus bits this device does not decode.
   logic unused_bus;
`ifdef UART_RX_PARITY_EN
   assign unused_bus = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                         device_wdata_i[31:5], device_wdata_i[1]};
`else
   assign unused_bus = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                         device_wdata_i[31:4], device_wdata_i[1]};
`endif

endmodule

// File: tb/tb_uart_rx_dev.sv
module tb_uart_rx_dev;
   localparam int CPB   = 10;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        rx = 1'b1;
   logic        irq;

   int checks = 0;
   int failures = 0;

   // Reference model: byte queue plus sticky error flags.
   logic [7:0] m_q[$];
   logic       m_ovr = 1'b0, m_frm = 1'b0, m_par = 1'b0;

   uart_rx_dev #(
      .ClockFrequency(1_000_000),
      .BaudRate      (100_000),
      .FifoDepth     (DEPTH)
   ) dut (
      .clk_sys_i      (clk),
      .rst_sys_ni     (rst_n),
      .device_req_i   (req),
      .device_addr_i  (addr),
      .device_we_i    (we),
      .device_be_i    (be),
      .device_wdata_i (wdata),
      .device_rvalid_o(rvalid),
      .device_rdata_o (rdata),
      .uart_rx_i      (rx),
      .rx_irq_o       (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_status();
      return {27'b0, m_par, m_frm, m_ovr, (m_q.size() == DEPTH), (m_q.size() != 0)};
   endfunction

   function automatic logic [31:0] exp_pop();
      if (m_q.size() == 0) return 32'h8000_0000;
      return {24'b0, m_q.pop_front()};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      tick(CPB);
   endtask

   // One frame; par_flip inverts the even-parity bit in parity builds.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
      if (par_flip) m_par = 1'b1;
`endif
      drive_bit(stop);
      rx = 1'b1;
      if (!stop) m_frm = 1'b1;
      else if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovr = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic v);
      req = 1'b1; we = 1'b0; be = 4'hF; addr = {28'h0, a, 2'b00};
      tick(1);
      req = 1'b0;
      v = rvalid; d = rdata;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] wd,
                            output logic [31:0] d, output logic v);
      req = 1'b1; we = 1'b1; be = 4'h1; addr = {28'h0, a, 2'b00}; wdata = wd;
      tick(1);
      req = 1'b0; we = 1'b0;
      v = rvalid; d = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      rst_n = 1'b0; rx = 1'b1;
      tick(3);
      checks++; if ({rvalid, irq, rdata} !== 34'h0) begin
         failures++; $display("FAIL reset_outputs: rvalid=%b irq=%b rdata=%h required 0", rvalid, irq, rdata);
      end
      rst_n = 1'b1;
      tick(5);
      bus_read(2'd1, d, v);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL reset_status: rvalid=%b data=%h required 1/00000000", v, d);
      end
      bus_read(2'd2, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL reset_ctrl: got %h required 00000000", d);
      end
   endtask

   task automatic test_basic();
      logic [31:0] d, e; logic v;
      send_frame(8'hA5, 1'b1, 1'b0);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h1) begin
         failures++; $display("FAIL basic_status: got %h required %h", d, e);
      end
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (d !== e || d !== 32'hA5) begin
         failures++; $display("FAIL basic_data: got %h required %h", d, e);
      end
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e) begin
         failures++; $display("FAIL basic_status_after: got %h required %h", d, e);
      end
   endtask

   task automatic test_empty_read();
      logic [31:0] d, e; logic v;
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (v !== 1'b1 || d !== e || d !== 32'h8000_0000) begin
         failures++; $display("FAIL empty_read: rvalid=%b data=%h required 1/%h", v, d, e);
      end
      tick(1);
      checks++; if (rvalid !== 1'b0) begin
         failures++; $display("FAIL rvalid_pulse: rvalid=%b required 0", rvalid);
      end
      bus_write(2'd0, 32'hFF, d, v);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL write_resp: rvalid=%b data=%h required 1/00000000", v, d);
      end
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e) begin
         failures++; $display("FAIL empty_status: got %h required %h", d, e);
      end
   endtask

   task automatic test_overrun();
      logic [31:0] d, e; logic v;
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h7) begin
         failures++; $display("FAIL overrun_status: got %h required %h", d, e);
      end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'd0, d, v); e = exp_pop();
         checks++; if (d !== e) begin
            failures++; $display("FAIL overrun_data%0d: got %h required %h", i, d, e);
         end
      end
      bus_write(2'd1, 32'h4, d, v); m_ovr = 1'b0;
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h0) begin
         failures++; $display("FAIL overrun_clear: got %h required %h", d, e);
      end
   endtask

   task automatic test_frame_err();
      logic [31:0] d, e; logic v;
      send_frame(8'h3C, 1'b0, 1'b0);
      tick(5);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h8) begin
         failures++; $display("FAIL frame_status: got %h required %h", d, e);
      end
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (d !== e) begin
         failures++; $display("FAIL frame_data: got %h required %h", d, e);
      end
      bus_write(2'd1, 32'h8, d, v); m_frm = 1'b0;
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e) begin
         failures++; $display("FAIL frame_clear: got %h required %h", d, e);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d, e; logic v;
      rx = 1'b0; tick(3); rx = 1'b1; tick(30);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h0) begin
         failures++; $display("FAIL glitch: got %h required %h", d, e);
      end
   endtask

   task automatic test_hold_low();
      logic [31:0] d, e; logic v;
      rx = 1'b0; rst_n = 1'b0; tick(3); rst_n = 1'b1;
      m_q.delete(); m_ovr = 0; m_frm = 0; m_par = 0;
      tick(150);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e) begin
         failures++; $display("FAIL hold_low: got %h required %h", d, e);
      end
      rx = 1'b1; tick(15);
      send_frame(8'h5A, 1'b1, 1'b0);
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (d !== e || d !== 32'h5A) begin
         failures++; $display("FAIL hold_low_next: got %h required %h", d, e);
      end
   endtask

   task automatic test_irq();
      logic [31:0] d, e; logic v;
      bus_write(2'd2, 32'h1, d, v);
      bus_read(2'd2, d, v);
      checks++; if (d !== 32'h1 || irq !== 1'b0) begin
         failures++; $display("FAIL irq_ctrl: ctrl=%h irq=%b required 00000001/0", d, irq);
      end
      send_frame(8'h55, 1'b1, 1'b0);
      checks++; if (irq !== 1'b1) begin
         failures++; $display("FAIL irq_rise: irq=%b required 1", irq);
      end
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (d !== e) begin
         failures++; $display("FAIL irq_data: got %h required %h", d, e);
      end
      tick(2);
      checks++; if (irq !== 1'b0) begin
         failures++; $display("FAIL irq_fall: irq=%b required 0", irq);
      end
      bus_write(2'd2, 32'h0, d, v);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, e; logic v;
      send_frame(8'h11, 1'b1, 1'b0);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b0);
      #2 rst_n = 1'b0;
      tick(2);
      checks++; if (rvalid !== 1'b0 || irq !== 1'b0) begin
         failures++; $display("FAIL midreset_outputs: rvalid=%b irq=%b required 0/0", rvalid, irq);
      end
      rx = 1'b1; rst_n = 1'b1;
      m_q.delete(); m_ovr = 0; m_frm = 0; m_par = 0;
      tick(5);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h0) begin
         failures++; $display("FAIL midreset_status: got %h required %h", d, e);
      end
      send_frame(8'h7E, 1'b1, 1'b0);
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (d !== e || d !== 32'h7E) begin
         failures++; $display("FAIL midreset_data: got %h required %h", d, e);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      logic [31:0] d, e; logic v;
      send_frame(8'h07, 1'b1, 1'b1);
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h11) begin
         failures++; $display("FAIL parity_status: got %h required %h", d, e);
      end
      bus_read(2'd0, d, v); e = exp_pop();
      checks++; if (d !== e || d !== 32'h07) begin
         failures++; $display("FAIL parity_data: got %h required %h", d, e);
      end
      bus_write(2'd1, 32'h10, d, v); m_par = 1'b0;
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e) begin
         failures++; $display("FAIL parity_clear: got %h required %h", d, e);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] d, e; logic v;
      logic [7:0] b; logic stop, pf;
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(5) != 0);
         pf   = ($urandom_range(5) == 0);
         send_frame(b, stop, pf);
         bus_read(2'd1, d, v); e = exp_status();
         checks++; if (d !== e) begin
            failures++; $display("FAIL rand_status%0d: got %h required %h", n, d, e);
         end
         for (int r = 0; r < int'($urandom_range(2)); r++) begin
            bus_read(2'd0, d, v); e = exp_pop();
            checks++; if (d !== e) begin
               failures++; $display("FAIL rand_data%0d: got %h required %h", n, d, e);
            end
         end
      end
      for (int r = 0; r <= DEPTH; r++) begin
         bus_read(2'd0, d, v); e = exp_pop();
         checks++; if (d !== e) begin
            failures++; $display("FAIL rand_drain%0d: got %h required %h", r, d, e);
         end
      end
      bus_write(2'd1, 32'h1C, d, v); m_ovr = 0; m_frm = 0; m_par = 0;
      bus_read(2'd1, d, v); e = exp_status();
      checks++; if (d !== e || d !== 32'h0) begin
         failures++; $display("FAIL rand_clear: got %h required %h", d, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_read();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_hold_low();
      test_irq();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
